// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store size codes, LSU state and lane helpers.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_WAIT = 1'b1
    } lsu_state_t;

    // size[1:0] picks the width class; codes 3, 6 and 7 fall through to word.
    function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
        case (size[1:0])
            2'b00:   lsu_be = 4'b0001 << off;
            2'b01:   lsu_be = off[1] ? 4'b1100 : 4'b0011;
            default: lsu_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] wd);
        case (size[1:0])
            2'b00:   lsu_wdata = {4{wd[7:0]}};
            2'b01:   lsu_wdata = {2{wd[15:0]}};
            default: lsu_wdata = wd;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] off);
        case (size[1:0])
            2'b00:   lsu_misaligned = 1'b0;
            2'b01:   lsu_misaligned = off[0];
            default: lsu_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side request and data-memory bus of the load/store unit, named from the LSU's view.
interface lsu_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, core_misalign_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, core_misalign_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/lsu_load_ext.sv
// Byte/halfword lane select and sign/zero extension of a memory read word.
module lsu_load_ext
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // size[2] marks the unsigned variants (BU/HU).
    always_comb begin
        case (size_i[1:0])
            2'b00:   data_o = {{24{byte_sel[7] & ~size_i[2]}}, byte_sel};
            2'b01:   data_o = {{16{half_sel[15] & ~size_i[2]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: issues one memory access per core request and stalls until ready.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_EXC_EN.
module riscv_lsu
    import riscv_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    lsu_if.slave  bus
);
    lsu_state_t  state_q, state_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] wd_q, wd_d;

    logic        mis;
    logic [31:0] ext_rd;

    logic [31:0] rd_o, addr_o, wdo;
    logic        stall_o, misal_o, req_o, we_o;
    logic [3:0]  be_o;

    lsu_load_ext u_load_ext (
        .rdata_i (bus.mem_rd_i),
        .size_i  (size_q),
        .off_i   (off_q),
        .data_o  (ext_rd)
    );

`ifdef LSU_MISALIGN_EXC_EN
    assign mis = lsu_misaligned(bus.core_size_i, bus.core_addr_i[1:0]);
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LSU_IDLE;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            we_q    <= 1'b0;
            waddr_q <= 30'd0;
            wd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            off_q   <= off_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wd_q    <= wd_d;
        end
    end

    // Outputs are gated by rst_ni so a held core request cannot leak out during reset.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        off_d   = off_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wd_d    = wd_q;
        rd_o    = 32'd0;
        stall_o = 1'b0;
        misal_o = 1'b0;
        req_o   = 1'b0;
        we_o    = 1'b0;
        be_o    = 4'd0;
        addr_o  = 32'd0;
        wdo     = 32'd0;
        if (rst_ni) begin
            case (state_q)
                LSU_IDLE: begin
                    if (bus.core_req_i) begin
                        if (mis) begin
                            misal_o = 1'b1;
                        end else begin
                            req_o   = 1'b1;
                            stall_o = 1'b1;
                            we_o    = bus.core_we_i;
                            be_o    = lsu_be(bus.core_size_i, bus.core_addr_i[1:0]);
                            addr_o  = {bus.core_addr_i[31:2], 2'b00};
                            wdo     = lsu_wdata(bus.core_size_i, bus.core_wd_i);
                            size_d  = bus.core_size_i;
                            off_d   = bus.core_addr_i[1:0];
                            we_d    = bus.core_we_i;
                            waddr_d = bus.core_addr_i[31:2];
                            wd_d    = bus.core_wd_i;
                            state_d = LSU_WAIT;
                        end
                    end
                end
                LSU_WAIT: begin
                    req_o   = 1'b1;
                    we_o    = we_q;
                    be_o    = lsu_be(size_q, off_q);
                    addr_o  = {waddr_q, 2'b00};
                    wdo     = lsu_wdata(size_q, wd_q);
                    stall_o = ~bus.mem_ready_i;
                    if (bus.mem_ready_i) begin
                        rd_o    = ext_rd;
                        state_d = LSU_IDLE;
                    end
                end
                default: state_d = LSU_IDLE;
            endcase
        end
    end

    assign bus.core_rd_o       = rd_o;
    assign bus.core_stall_o    = stall_o;
    assign bus.core_misalign_o = misal_o;
    assign bus.mem_req_o       = req_o;
    assign bus.mem_we_o        = we_o;
    assign bus.mem_be_o        = be_o;
    assign bus.mem_addr_o      = addr_o;
    assign bus.mem_wd_o        = wdo;
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit sitting directly downstream of the instruction decoder in the single-cycle RISC-V core. It consumes the decoder's memory-request, write-enable and access-size outputs together with the ALU-computed address and rs2 data. It drives a word-addressed, byte-enabled data memory with a ready handshake, and stalls the core until each access completes. Load data is returned byte/halfword-selected and sign- or zero-extended for register write-back.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_req_i  in  1  memory access requested (decoder mem_req)
- core_we_i  in  1  1 = store, 0 = load (decoder mem_we)
- core_size_i  in  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5
- core_addr_i  in  32  byte address from ALU
- core_wd_i  in  32  store data (rs2)
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  hold PC/pipeline this cycle
- core_misalign_o  out  1  misaligned access detected (see Configuration)
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wd_o  out  32  replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  access complete

## Operation
- FSM states: IDLE, WAIT. Reset state IDLE.
- IDLE, core_req_i=1, access legal:
  - mem_req_o=1 and core_stall_o=1.
  - At the edge, register size and addr[1:0], then go to WAIT.
  - mem_ready_i is ignored in IDLE.
- WAIT:
  - mem_req_o=1, with mem_we_o/mem_be_o/mem_wd_o/mem_addr_o held from the registered request.
  - core_stall_o = !mem_ready_i.
  - On mem_ready_i=1: core_rd_o is valid in that cycle, and the FSM returns to IDLE.
- core_req_i=0 in IDLE: mem_req_o=0, core_stall_o=0.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: addr[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
  - Loads use the same rule.
- Store data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Load extension uses the registered offset:
  - B: sign-extend the selected byte; BU: zero-extend it.
  - H: sign-extend the selected halfword; HU: zero-extend it.
  - W: the full word.
- Unused size codes (3, 6, 7) behave as W.
- Outputs are combinational from state and registers. core_rd_o is 0 outside WAIT&mem_ready_i.

## Timing
- Minimum access latency: 2 cycles (issue cycle in IDLE, then completion cycle in WAIT with mem_ready_i=1). Stall asserted 1 + N cycles for N wait cycles in WAIT.
- Core holds core_* stable while core_stall_o=1. The LSU never re-issues the same request: after completion the next core_req_i is a new instruction.
- Reset values: state IDLE, registered size/offset 0.
- Outputs under reset: mem_req_o=0, core_stall_o=0, core_misalign_o=0, mem_be_o=0, core_rd_o=0.
- Reset asserted mid-WAIT: the FSM returns to IDLE immediately (asynchronous) and mem_req_o drops that cycle.

## Configuration
- Macro LSU_MISALIGN_EXC_EN.
- Defined:
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - A misaligned access in IDLE asserts core_misalign_o for that cycle only.
  - No memory request is issued, no stall occurs, and the FSM stays in IDLE.
- Undefined:
  - core_misalign_o tied 0.
  - H ignores addr[0] and W ignores addr[1:0]; the access is issued aligned.

## Structure
- LDST_* size constants are in riscv_pkg (already present). State enum lsu_state_t is added to riscv_pkg.
- One sub-module, lsu_load_ext: combinational byte/halfword select and extension from (mem_rd_i, size, offset).

## Test plan
- SW addr 0x104, wd 0xDEADBEEF, mem_ready_i after 2 wait cycles:
  - mem_be_o=1111, mem_addr_o=0x104, mem_wd_o=0xDEADBEEF.
  - Stall high 3 cycles, low on the ready cycle.
- SB addr 0x203, wd 0x000000A5 -> mem_be_o=1000, mem_wd_o=0xA5A5A5A5, mem_addr_o=0x200.
- LB then LBU at addr 0x01, mem_rd_i=0x00008000 (byte 0x80) -> core_rd_o=0xFFFFFF80, then 0x00000080.
- LH addr 0x02, mem_rd_i=0x80010000 -> core_rd_o=0xFFFF8001; LHU -> 0x00008001.
- LW addr 0x06:
  - With LSU_MISALIGN_EXC_EN: core_misalign_o=1 for one cycle, mem_req_o=0, no stall.
  - Without it: mem_addr_o=0x04, mem_be_o=1111.
- rst_ni pulsed low in WAIT -> mem_req_o and core_stall_o drop that cycle. After release, the next core_req_i is issued from IDLE normally.
